axi4_lite_read_arbiter: RTL and testbench
=========================================

# axi4_lite_read_arbiter

Round-robin arbiter that shares one AXI4-Lite read slave port (such as our AXI4 read-side register interface) between up to four read masters (core load unit, debug port, DMA). It accepts one read address at a time, forwards it to the slave, and routes the single read response back to the granted master before it grants the next request. There are no outstanding transactions beyond one, and IDs are never reordered.

## Interface
- NUM_MASTERS, 2, number of requesters, legal 2..4
- ADDRESS_WIDTH, 32, address width on all ports
- TIMEOUT_CYCLES, 255, slave-hang limit in cycles; used only with the timeout feature; legal 1..65535
- axi_clk  in  1  clock, all logic on the rising edge
- resetn  in  1  reset; synchronous, active-low
- m_araddr  in  NUM_MASTERS*ADDRESS_WIDTH  master i address at slice i
- m_arvalid  in  NUM_MASTERS  per-master address valid
- m_arready  out  NUM_MASTERS  per-master address ready
- m_rdata  out  NUM_MASTERS*32  read data, broadcast to all slices
- m_rresp  out  NUM_MASTERS*2  read response, broadcast to all slices
- m_rvalid  out  NUM_MASTERS  per-master read valid; only the granted bit can be set
- m_rready  in  NUM_MASTERS  per-master read ready
- s_araddr  out  ADDRESS_WIDTH  slave address, registered
- s_arvalid  out  1  slave address valid, registered
- s_arready  in  1  slave address ready
- s_rdata  in  32  slave read data
- s_rresp  in  2  slave response
- s_rvalid  in  1  slave read valid
- s_rready  out  1  slave read ready
- grant_id  out  2  index of the current or last granted master
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ADDR, RESP, and ERR (ERR exists only with the timeout feature).
- IDLE:
  - Winner is the first master with m_arvalid set, searching from (last_grant+1) mod NUM_MASTERS upward with wrap-around.
  - m_arready[winner] is driven combinationally high in that same cycle, so the handshake completes.
  - On that handshake: latch m_araddr[winner] into s_araddr, set grant_id to winner, and move to ADDR.
  - No m_arvalid: stay in IDLE with every m_arready low.
- ADDR:
  - s_arvalid is high. s_araddr is held stable.
  - On s_arvalid & s_arready: clear s_arvalid and move to RESP.
- RESP:
  - s_rready = m_rready[grant_id]; m_rvalid[grant_id] = s_rvalid; m_rdata = s_rdata; m_rresp = s_rresp. All combinational pass-through.
  - On s_rvalid & s_rready: last_grant is set to grant_id, move to IDLE.
- Outside RESP, s_rready = 0 and all m_rvalid = 0.
- A master that drops m_arvalid before it is granted simply loses its turn. This is not an error.
- s_rresp values pass through unmodified, including SLVERR.

## Timing
- Reset values:
  - s_arvalid 0, s_araddr 0, grant_id 0, busy 0.
  - All m_arready, m_rvalid and s_rready are 0.
  - m_rdata and m_rresp are 0.
  - last_grant is NUM_MASTERS-1, so master 0 has first priority after reset.
- Reset asserted mid-transaction: next state is IDLE and the transaction is abandoned. The slave is reset in the same domain.
- Latency, with a zero-wait slave:
  - Cycle 0: master AR handshake.
  - Cycle 1: s_arvalid and s_arready handshake.
  - Cycle 2: R handshake, same-cycle pass-through to the master.
  - Cycle 3: IDLE, where a new grant is possible.
- Peak throughput is one read per 3 cycles.
- Simultaneous requests: exactly one m_arready bit is high per cycle. Round-robin guarantees each requester is served within NUM_MASTERS grants.
- Requests arriving during ADDR, RESP or ERR are held off (m_arready low) until IDLE.

## Configuration
- AXI_RD_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to ADDR and RESP and increments each cycle the state has no handshake.
  - When the counter reaches TIMEOUT_CYCLES: s_arvalid drops to 0 and s_rready to 0, and the FSM enters ERR.
  - ERR drives m_rvalid[grant_id]=1, m_rdata=0, m_rresp=2'b10 (SLVERR) until m_rready[grant_id], then moves to IDLE and updates last_grant.
  - A hung slave must be reset before further use. Late slave responses are unsupported.
- AXI_RD_ARB_TIMEOUT_EN undefined: no counter and no ERR state. The FSM waits indefinitely in ADDR and RESP.

## Test plan
- Single read: master 0 reads 0x0000_0010, slave returns 0xDEADBEEF with OKAY and zero wait -> m_arready[0] in cycle 0, s_arvalid in cycle 1, m_rvalid[0] with 0xDEADBEEF and resp 00 in cycle 2, busy low in cycle 3.
- Contention: after reset, masters 0 and 1 hold m_arvalid continuously for 4 reads each -> grant order 0,1,0,1,0,1,0,1 and grant_id matches on each response.
- Backpressure: slave holds s_arready low for 5 cycles, then master 1 holds m_rready low for 3 cycles after s_rvalid -> s_araddr stable throughout, s_rready follows m_rready[1], data delivered once.
- Slave error: slave returns s_rresp=2'b10 with data 0x1234 -> the master sees 2'b10 and 0x1234 unchanged.
- Reset mid-RESP: resetn low for 1 cycle while s_rvalid=0 -> all outputs return to reset values and the next request from master 0 is granted first.
- With AXI_RD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: slave never asserts s_rvalid -> after 8 cycles in RESP, s_rready=0 and m_rvalid[grant]=1 with data 0 and resp 2'b10, then IDLE.

Source files
------------

// File: rtl/axi4_lite_read_arbiter_if.sv
// axi4_lite_read_arbiter_if: requester-side and slave-side AXI4-Lite read channels of the arbiter.
// master modport is the arbiter's view; slave modport is the surrounding masters and slave.
interface axi4_lite_read_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDRESS_WIDTH = 32
);
  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_araddr;
  logic [NUM_MASTERS-1:0] m_arvalid;
  logic [NUM_MASTERS-1:0] m_arready;
  logic [NUM_MASTERS*32-1:0] m_rdata;
  logic [NUM_MASTERS*2-1:0] m_rresp;
  logic [NUM_MASTERS-1:0] m_rvalid;
  logic [NUM_MASTERS-1:0] m_rready;
  logic [ADDRESS_WIDTH-1:0] s_araddr;
  logic s_arvalid;
  logic s_arready;
  logic [31:0] s_rdata;
  logic [1:0] s_rresp;
  logic s_rvalid;
  logic s_rready;
  modport master (
    input m_araddr, m_arvalid, m_rready, s_arready, s_rdata, s_rresp, s_rvalid,
    output m_arready, m_rdata, m_rresp, m_rvalid, s_araddr, s_arvalid, s_rready
  );
  modport slave (
    output m_araddr, m_arvalid, m_rready, s_arready, s_rdata, s_rresp, s_rvalid,
    input m_arready, m_rdata, m_rresp, m_rvalid, s_araddr, s_arvalid, s_rready
  );
endinterface

// File: rtl/axi4_lite_read_arbiter.sv
// axi4_lite_read_arbiter: round-robin sharing of one AXI4-Lite read slave among NUM_MASTERS requesters,
// one transaction at a time. Define AXI_RD_ARB_TIMEOUT_EN to add the slave-hang timeout and ERR state.
module axi4_lite_read_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDRESS_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic axi_clk,
  input logic resetn,
  axi4_lite_read_arbiter_if.master bus,
  output logic [1:0] grant_id,
  output logic busy
);
  localparam int IW = $clog2(NUM_MASTERS);
`ifdef AXI_RD_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, ADDR, RESP, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
`endif
  state_t r_state;
  logic [1:0] r_last;
  logic [1:0] r_grant;
  logic [ADDRESS_WIDTH-1:0] r_araddr;
  logic r_arvalid;
  logic [1:0] w_win;
  logic w_found;
  logic [IW-1:0] w_gsel;
  logic w_rhs;
  logic w_err;
  // Scan from last_grant+NUM_MASTERS down to last_grant+1 so the nearest successor wins.
  always_comb begin
    w_found = 1'b0;
    w_win = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      if (bus.m_arvalid[IW'((int'(r_last) + k) % NUM_MASTERS)]) begin
        w_found = 1'b1;
        w_win = 2'((int'(r_last) + k) % NUM_MASTERS);
      end
    end
  end
  assign w_gsel = IW'(r_grant);
  assign w_rhs = bus.s_rvalid & bus.m_rready[w_gsel];
  assign busy = r_state != IDLE;
  assign grant_id = r_grant;
  assign bus.s_araddr = r_araddr;
  assign bus.s_arvalid = r_arvalid;
  assign bus.m_arready = (r_state == IDLE && w_found) ? (NUM_MASTERS'(1) << w_win) : '0;
  assign bus.s_rready = (r_state == RESP) & bus.m_rready[w_gsel];
`ifdef AXI_RD_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic w_to;
  assign w_err = r_state == ERR;
  assign w_to = r_cnt == 16'(TIMEOUT_CYCLES - 1);
`else
  assign w_err = 1'b0;
`endif
  assign bus.m_rvalid = ((r_state == RESP && bus.s_rvalid) || w_err) ? (NUM_MASTERS'(1) << r_grant) : '0;
  assign bus.m_rdata = {NUM_MASTERS{r_state == RESP ? bus.s_rdata : 32'd0}};
  assign bus.m_rresp = {NUM_MASTERS{r_state == RESP ? bus.s_rresp : w_err ? 2'b10 : 2'b00}};
  always_ff @(posedge axi_clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_last <= 2'(NUM_MASTERS - 1);
      r_grant <= '0;
      r_araddr <= '0;
      r_arvalid <= 1'b0;
`ifdef AXI_RD_ARB_TIMEOUT_EN
      r_cnt <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_found) begin
          r_araddr <= bus.m_araddr[int'(w_win)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          r_grant <= w_win;
          r_arvalid <= 1'b1;
          r_state <= ADDR;
        end
        ADDR: if (bus.s_arready) begin
          r_arvalid <= 1'b0;
          r_state <= RESP;
        end
        RESP: if (w_rhs) begin
          r_last <= r_grant;
          r_state <= IDLE;
        end
`ifdef AXI_RD_ARB_TIMEOUT_EN
        ERR: if (bus.m_rready[w_gsel]) begin
          r_last <= r_grant;
          r_state <= IDLE;
        end
`endif
        default: r_state <= IDLE;
      endcase
`ifdef AXI_RD_ARB_TIMEOUT_EN
      r_cnt <= (r_state == IDLE || (r_state == ADDR && bus.s_arready)) ? '0 : r_cnt + 16'd1;
      if (w_to && ((r_state == ADDR && !bus.s_arready) || (r_state == RESP && !w_rhs))) begin
        r_arvalid <= 1'b0;
        r_state <= ERR;
      end
`endif
    end
  end
endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// tb_axi4_lite_read_arbiter: directed reads through the arbiter with a queue-based response scoreboard.
module tb_axi4_lite_read_arbiter;
  localparam int NM = 2;
  localparam int AW = 32;
  typedef struct {
    int mst;
    logic [31:0] data;
    logic [1:0] resp;
  } exp_t;
  logic axi_clk = 1'b0;
  logic resetn = 1'b0;
  logic [1:0] grant_id;
  logic busy;
  axi4_lite_read_arbiter_if #(.NUM_MASTERS(NM), .ADDRESS_WIDTH(AW)) bus();
  axi4_lite_read_arbiter #(.NUM_MASTERS(NM), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
    .axi_clk(axi_clk),
    .resetn(resetn),
    .bus(bus.master),
    .grant_id(grant_id),
    .busy(busy)
  );
  always #5 axi_clk = ~axi_clk;
  exp_t exp_q[$];
  logic [31:0] mq[NM][$];
  int n_checks = 0;
  int n_fail = 0;
  int n_resp = 0;
  int ar_wait = 0;
  int r_wait = 0;
  logic hang = 1'b0;
  int rr_cfg[NM] = '{default: 0};
  int hold[NM];
  logic [NM-1:0] m_ar_done = '0;
  logic [NM-1:0] rv_q = '0;
  logic ar_done = 1'b0;
  logic r_done = 1'b0;
  always @(posedge axi_clk) begin
    m_ar_done <= bus.m_arvalid & bus.m_arready;
    rv_q <= bus.m_rvalid;
    ar_done <= bus.s_arvalid & bus.s_arready;
    r_done <= bus.s_rvalid & bus.s_rready;
  end
  // Slave model: data is the address XOR a fixed pattern, response code is address bits 13:12.
  function automatic logic [31:0] sl_data(input logic [31:0] a);
    return a ^ 32'hDEADBEFF;
  endfunction
  function automatic logic [1:0] sl_resp(input logic [31:0] a);
    return a[13:12];
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  // Requesters: present queued addresses, optionally stall rready after the response appears.
  initial begin
    bus.m_arvalid = '0;
    bus.m_araddr = '0;
    bus.m_rready = '1;
    for (int i = 0; i < NM; i++) hold[i] = 0;
    forever begin
      @(posedge axi_clk);
      #1;
      for (int i = 0; i < NM; i++) begin
        if (!resetn) begin
          bus.m_arvalid[i] = 1'b0;
          hold[i] = 0;
        end else begin
          if (m_ar_done[i] && mq[i].size() > 0) begin
            void'(mq[i].pop_front());
            hold[i] = rr_cfg[i];
          end
          bus.m_arvalid[i] = mq[i].size() > 0;
          if (mq[i].size() > 0) bus.m_araddr[i*AW +: AW] = mq[i][0];
        end
        if (rv_q[i] && hold[i] > 0) hold[i]--;
        bus.m_rready[i] = hold[i] == 0;
      end
    end
  end
  int sl_st;
  int sl_cnt;
  logic [31:0] sl_addr;
  initial begin
    bus.s_arready = 1'b0;
    bus.s_rvalid = 1'b0;
    bus.s_rdata = '0;
    bus.s_rresp = '0;
    sl_st = 0;
    sl_cnt = 0;
    sl_addr = '0;
    forever begin
      @(posedge axi_clk);
      #1;
      if (!resetn) begin
        sl_st = 0;
        sl_cnt = 0;
        bus.s_arready = 1'b0;
        bus.s_rvalid = 1'b0;
      end else begin
        if (sl_st == 2 && r_done) begin
          bus.s_rvalid = 1'b0;
          sl_st = 0;
        end
        if (sl_st == 0 && ar_done) begin
          bus.s_arready = 1'b0;
          sl_cnt = 0;
          sl_st = 1;
        end else if (sl_st == 0 && bus.s_arvalid) begin
          if (sl_cnt >= ar_wait) begin
            bus.s_arready = 1'b1;
            sl_addr = bus.s_araddr;
          end else sl_cnt++;
        end
        if (sl_st == 1 && !hang) begin
          if (sl_cnt >= r_wait) begin
            bus.s_rvalid = 1'b1;
            bus.s_rdata = sl_data(sl_addr);
            bus.s_rresp = sl_resp(sl_addr);
            sl_st = 2;
          end else sl_cnt++;
        end
      end
    end
  end
  exp_t mon_e;
  logic [NM-1:0] mon_hs;
  always @(negedge axi_clk) begin
    if (resetn) begin
      if (!busy && |bus.m_arvalid) chk("ar_onehot", 64'($countones(bus.m_arready)), 64'd1);
      mon_hs = bus.m_rvalid & bus.m_rready;
      if (mon_hs != '0) begin
        if (exp_q.size() == 0) chk("resp_unexpected", 64'(mon_hs), 64'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk("resp_master", 64'(mon_hs), 64'(1) << mon_e.mst);
          chk("resp_grant_id", 64'(grant_id), 64'(mon_e.mst));
          chk("resp_data", 64'(bus.m_rdata[mon_e.mst*32 +: 32]), 64'(mon_e.data));
          chk("resp_code", 64'(bus.m_rresp[mon_e.mst*2 +: 2]), 64'(mon_e.resp));
        end
        n_resp++;
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(negedge axi_clk);
  endtask
  task automatic issue_x(input int m, input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    mq[m].push_back(a);
    exp_q.push_back('{mst: m, data: d, resp: r});
  endtask
  task automatic issue(input int m, input logic [31:0] a);
    issue_x(m, a, sl_data(a), sl_resp(a));
  endtask
  task automatic drain();
    for (int c = 0; c < 300 && (exp_q.size() > 0 || busy); c++) tick();
    chk("drain", 64'(exp_q.size()), 64'd0);
    tick();
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_s_arvalid"}, 64'(bus.s_arvalid), 64'd0);
    chk({tag, "_s_araddr"}, 64'(bus.s_araddr), 64'd0);
    chk({tag, "_grant_id"}, 64'(grant_id), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_m_arready"}, 64'(bus.m_arready), 64'd0);
    chk({tag, "_m_rvalid"}, 64'(bus.m_rvalid), 64'd0);
    chk({tag, "_s_rready"}, 64'(bus.s_rready), 64'd0);
    chk({tag, "_m_rdata"}, bus.m_rdata, 64'd0);
    chk({tag, "_m_rresp"}, 64'(bus.m_rresp), 64'd0);
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    ar_wait = 0;
    r_wait = 0;
    hang = 1'b0;
    rr_cfg = '{default: 0};
    tick(2);
    resetn = 1'b1;
  endtask
  int start_resp;
  int stalls;
  int cyc;
  initial begin
    tick(3);
    chk_reset("rst");
    resetn = 1'b1;
    issue_x(0, 32'h0000_0010, 32'hDEADBEEF, 2'b00);
    tick();
    chk("c0_m_arready", 64'(bus.m_arready), 64'b01);
    tick();
    chk("c1_s_arvalid", 64'(bus.s_arvalid), 64'd1);
    chk("c1_s_araddr", 64'(bus.s_araddr), 64'h10);
    tick();
    chk("c2_m_rvalid", 64'(bus.m_rvalid), 64'b01);
    chk("c2_m_rdata", 64'(bus.m_rdata[31:0]), 64'hDEADBEEF);
    tick();
    chk("c3_busy", 64'(busy), 64'd0);
    drain();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(0, 32'h100 + 32'(4 * i));
      issue(1, 32'h200 + 32'(4 * i));
    end
    drain();
    ar_wait = 5;
    rr_cfg[1] = 3;
    issue(1, 32'h0000_0340);
    start_resp = n_resp;
    stalls = 0;
    for (int c = 0; c < 40 && n_resp == start_resp; c++) begin
      tick();
      if (bus.s_arvalid) chk("bp_araddr_stable", 64'(bus.s_araddr), 64'h340);
      if (busy && !bus.s_arvalid) chk("bp_rready_follow", 64'(bus.s_rready), 64'(bus.m_rready[1]));
      if (bus.m_rvalid[1] && !bus.m_rready[1]) stalls++;
    end
    chk("bp_stall_cycles", 64'(stalls), 64'd3);
    ar_wait = 0;
    rr_cfg[1] = 0;
    drain();
    chk("bp_delivered_once", 64'(n_resp - start_resp), 64'd1);
    issue_x(0, 32'hDEADACCB, 32'h0000_1234, 2'b10);
    drain();
    r_wait = 10;
    mq[0].push_back(32'h0000_0020);
    for (int c = 0; c < 30 && !(busy && !bus.s_arvalid); c++) tick();
    chk("mid_resp_reached", 64'(busy && !bus.s_arvalid && !bus.s_rvalid), 64'd1);
    resetn = 1'b0;
    r_wait = 0;
    tick();
    chk_reset("mid_rst");
    resetn = 1'b1;
    issue(0, 32'h0000_0500);
    issue(1, 32'h0000_0400);
    drain();
`ifdef AXI_RD_ARB_TIMEOUT_EN
    hang = 1'b1;
    issue_x(0, 32'h0000_0030, 32'h0, 2'b10);
    cyc = 0;
    for (int c = 0; c < 40 && bus.m_rvalid == '0; c++) begin
      tick();
      if (busy && !bus.s_arvalid && bus.m_rvalid == '0) cyc++;
    end
    chk("to_resp_cycles", 64'(cyc), 64'd8);
    chk("to_s_rready", 64'(bus.s_rready), 64'd0);
    drain();
    do_reset();
`endif
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
